// File: rtl/floor_scheduler_if.sv
// Floor scheduler bus: time-base strobe, call inputs, door buttons and the
// car status outputs consumed by the display/lamp logic.
interface floor_scheduler_if #(
  parameter int FLOORS = 8,
  parameter int FW     = 3
);
  logic              tick;
  logic [FLOORS-1:0] out_req;
  logic [FLOORS-1:0] in_req;
  logic              open_door_bnt;
  logic              close_door_bnt;
  logic [FW-1:0]     floor;
  logic [FLOORS-1:0] floor_req;
  logic              up_lamp;
  logic              down_lamp;
  logic              door_open_lamp;
  logic              door_close_lamp;
  logic [3:0]        count_run_time;
  logic [2:0]        count_door_time;

  // Driver side: produces ticks, calls and button levels.
  modport master (
    output tick, out_req, in_req, open_door_bnt, close_door_bnt,
    input  floor, floor_req, up_lamp, down_lamp, door_open_lamp,
           door_close_lamp, count_run_time, count_door_time
  );

  // Scheduler side.
  modport slave (
    input  tick, out_req, in_req, open_door_bnt, close_door_bnt,
    output floor, floor_req, up_lamp, down_lamp, door_open_lamp,
           door_close_lamp, count_run_time, count_door_time
  );
endinterface

// File: rtl/floor_scheduler.sv
// LOOK-order elevator car scheduler: latches hall/cab calls, chooses the
// travel direction, steps the car one floor per RUN_TICKS ticks and runs
// the door open/hold/close sequence with button override.
module floor_scheduler #(
  parameter int FLOORS     = 8,
  parameter int FW         = 3,
  parameter int RUN_TICKS  = 3,
  parameter int DOOR_TICKS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  floor_scheduler_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_ARRIVE = 2'd2,
    S_DOOR   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  state_t            r_state;
  logic              r_dir;
  logic [FW-1:0]     r_floor;
  logic [FLOORS-1:0] r_floor_req;
  logic [3:0]        r_run;
  logic [2:0]        r_door;
  logic              r_up_lamp;
  logic              r_down_lamp;
  logic              r_door_open_lamp;

  state_t            w_state_nx;
  logic              w_dir_nx;
  logic [FW-1:0]     w_floor_nx;
  logic [FLOORS-1:0] w_req_nx;
  logic [3:0]        w_run_nx;
  logic [2:0]        w_door_nx;
  logic [FLOORS-1:0] w_calls;
  logic [FLOORS-1:0] w_here_mask;
  logic              w_here;
  logic              w_above;
  logic              w_below;
  logic              w_call_here;

  // Pending-call geometry relative to the car: above, below and at this floor.
  always_comb begin
    w_calls     = bus.out_req | bus.in_req;
    w_here_mask = {{(FLOORS-1){1'b0}}, 1'b1} << r_floor;
    w_here      = |(r_floor_req & w_here_mask);
    w_call_here = |(w_calls & w_here_mask);
    w_above     = 1'b0;
    w_below     = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (r_floor_req[i] && (i > int'(r_floor))) begin
        w_above = 1'b1;
      end else if (r_floor_req[i] && (i < int'(r_floor))) begin
        w_below = 1'b1;
      end else begin
        w_above = w_above;
      end
    end
  end

  // Next state, direction, floor and timers for the LOOK sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_floor_nx = r_floor;
    w_run_nx   = r_run;
    w_door_nx  = r_door;
    case (r_state)
      S_IDLE: begin
        if (w_here || bus.open_door_bnt) begin
          w_state_nx = S_DOOR;
          w_door_nx  = 3'd0;
        end else if (w_above && ((r_dir == DIR_UP) || !w_below)) begin
          w_dir_nx   = DIR_UP;
          w_state_nx = S_MOVE;
          w_run_nx   = 4'd0;
        end else if (w_below) begin
          w_dir_nx   = DIR_DOWN;
          w_state_nx = S_MOVE;
          w_run_nx   = 4'd0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_MOVE: begin
        // Door buttons have no effect while travelling.
        if (bus.tick && (r_run == 4'(RUN_TICKS - 1))) begin
          w_run_nx   = 4'd0;
          w_state_nx = S_ARRIVE;
          if (r_dir == DIR_UP) begin
            w_floor_nx = r_floor + FW'(1);
          end else begin
            w_floor_nx = r_floor - FW'(1);
          end
        end else if (bus.tick) begin
          w_run_nx = r_run + 4'd1;
        end else begin
          w_run_nx = r_run;
        end
      end
      S_ARRIVE: begin
        if (w_here) begin
          w_state_nx = S_DOOR;
          w_door_nx  = 3'd0;
        end else if ((r_dir == DIR_UP) ? w_above : w_below) begin
          w_state_nx = S_MOVE;
        end else if ((r_dir == DIR_UP) ? w_below : w_above) begin
          w_dir_nx   = ~r_dir;
          w_state_nx = S_MOVE;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_DOOR: begin
        // Open button beats close and the timer; a fresh call here re-arms the hold.
        if (bus.open_door_bnt) begin
          w_door_nx = 3'd0;
        end else if (bus.close_door_bnt ||
                     (bus.tick && (r_door == 3'(DOOR_TICKS - 1)))) begin
          w_door_nx  = 3'd0;
          w_state_nx = S_IDLE;
        end else if (w_call_here) begin
          w_door_nx = 3'd0;
        end else if (bus.tick) begin
          w_door_nx = r_door + 3'd1;
        end else begin
          w_door_nx = r_door;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_run_nx   = 4'd0;
        w_door_nx  = 3'd0;
      end
    endcase
  end

  // Call latch: accumulate new calls, never hold the call for an open-door floor.
  always_comb begin
    if ((r_state == S_DOOR) || (w_state_nx == S_DOOR)) begin
      w_req_nx = (r_floor_req | w_calls) & ~w_here_mask;
    end else begin
      w_req_nx = r_floor_req | w_calls;
    end
  end

  // State, position, call and lamp registers; reset abandons any run at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_dir            <= DIR_UP;
      r_floor          <= '0;
      r_floor_req      <= '0;
      r_run            <= 4'd0;
      r_door           <= 3'd0;
      r_up_lamp        <= 1'b0;
      r_down_lamp      <= 1'b0;
      r_door_open_lamp <= 1'b0;
    end else begin
      r_state          <= w_state_nx;
      r_dir            <= w_dir_nx;
      r_floor          <= w_floor_nx;
      r_floor_req      <= w_req_nx;
      r_run            <= w_run_nx;
      r_door           <= w_door_nx;
      r_up_lamp        <= ((w_state_nx == S_MOVE) || (w_state_nx == S_ARRIVE)) && (w_dir_nx == DIR_UP);
      r_down_lamp      <= ((w_state_nx == S_MOVE) || (w_state_nx == S_ARRIVE)) && (w_dir_nx == DIR_DOWN);
      r_door_open_lamp <= (w_state_nx == S_DOOR);
    end
  end

  assign bus.floor           = r_floor;
  assign bus.floor_req       = r_floor_req;
  assign bus.up_lamp         = r_up_lamp;
  assign bus.down_lamp       = r_down_lamp;
  assign bus.door_open_lamp  = r_door_open_lamp;
  assign bus.door_close_lamp = ~r_door_open_lamp;
  assign bus.count_run_time  = r_run;
  assign bus.count_door_time = r_door;

endmodule

// File: tb/tb_floor_scheduler.sv
// Self-checking bench for floor_scheduler: expected door-open floors are
// queued when calls are issued and checked when the door opens; status
// outputs are checked directly against hand-derived values.
module tb_floor_scheduler;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   exp_floor_q[$];
  logic prev_open;

  floor_scheduler_if #(.FLOORS(8), .FW(3)) bus ();

  floor_scheduler #(.FLOORS(8), .FW(3), .RUN_TICKS(3), .DOOR_TICKS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each door opening must be at the next queued floor.
  always @(negedge clk) begin
    if (reset && bus.door_open_lamp && !prev_open) begin
      if (exp_floor_q.size() == 0) begin
        chk("sb_unexpected_open", 32'(bus.floor), 32'hFFFF);
      end else begin
        chk("sb_door_floor", 32'(bus.floor), 32'(exp_floor_q.pop_front()));
      end
    end
    prev_open <= reset ? bus.door_open_lamp : 1'b0;
  end

  // One tick strobe followed by idle clocks so ARRIVE never sees a tick.
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); bus.tick = 1'b1;
      @(negedge clk); bus.tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic wait_door(input int budget);
    for (int k = 0; k < budget && !bus.door_open_lamp; k++) run_ticks(1);
    chk("door_reached", 32'(bus.door_open_lamp), 32'd1);
  endtask

  task automatic pulse_in(input logic [7:0] v);
    @(negedge clk); bus.in_req = v;
    @(negedge clk); bus.in_req = 8'h00;
  endtask

  task automatic pulse_out(input logic [7:0] v);
    @(negedge clk); bus.out_req = v;
    @(negedge clk); bus.out_req = 8'h00;
  endtask

  // Hard stop in case the run wanders off.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; prev_open = 1'b0;
    reset = 1'b0;
    bus.tick = 1'b0; bus.out_req = 8'h00; bus.in_req = 8'h00;
    bus.open_door_bnt = 1'b0; bus.close_door_bnt = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_floor", 32'(bus.floor), 32'd0);
    chk("rst_req", 32'(bus.floor_req), 32'd0);
    chk("rst_close_lamp", 32'(bus.door_close_lamp), 32'd1);
    chk("rst_lamps", 32'({bus.up_lamp, bus.down_lamp, bus.door_open_lamp}), 32'd0);
    chk("rst_counts", 32'({bus.count_run_time, bus.count_door_time}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Cab call to floor 3
    pulse_in(8'b0000_1000); exp_floor_q.push_back(3);
    chk("req_latched", 32'(bus.floor_req), 32'h08);
    chk("idle_before_move", 32'(bus.up_lamp), 32'd0);
    @(negedge clk);
    chk("up_lamp_move", 32'(bus.up_lamp), 32'd1);
    run_ticks(2);
    chk("run_count_2", 32'(bus.count_run_time), 32'd2);
    chk("floor_still_0", 32'(bus.floor), 32'd0);
    run_ticks(1);
    chk("floor_1", 32'(bus.floor), 32'd1);
    chk("run_count_wrap", 32'(bus.count_run_time), 32'd0);
    run_ticks(6);
    chk("at_floor_3", 32'(bus.floor), 32'd3);
    chk("door_open_3", 32'(bus.door_open_lamp), 32'd1);
    chk("req3_cleared", 32'(bus.floor_req), 32'd0);
    chk("no_up_in_door", 32'(bus.up_lamp), 32'd0);
    run_ticks(4);
    chk("door_hold_4", 32'(bus.door_open_lamp), 32'd1);
    chk("door_count_4", 32'(bus.count_door_time), 32'd4);
    run_ticks(1);
    chk("door_closed_timer", 32'(bus.door_close_lamp), 32'd1);
    chk("door_count_reset", 32'(bus.count_door_time), 32'd0);

    // LOOK order: going up with calls at 6 and 1
    pulse_in(8'b0100_0000); exp_floor_q.push_back(6);
    run_ticks(3);
    chk("floor_4", 32'(bus.floor), 32'd4);
    chk("up_to_4", 32'(bus.up_lamp), 32'd1);
    pulse_out(8'b0000_0010); exp_floor_q.push_back(1);
    wait_door(20);
    chk("served_6_first", 32'(bus.floor), 32'd6);

    // Open button restarts hold; close button ends it
    run_ticks(3);
    chk("door_count_3", 32'(bus.count_door_time), 32'd3);
    @(negedge clk); bus.open_door_bnt = 1'b1;
    @(negedge clk); bus.open_door_bnt = 1'b0;
    chk("open_btn_count0", 32'(bus.count_door_time), 32'd0);
    run_ticks(4);
    chk("open_btn_hold", 32'(bus.door_open_lamp), 32'd1);
    @(negedge clk); bus.close_door_bnt = 1'b1;
    @(negedge clk); bus.close_door_bnt = 1'b0;
    chk("close_btn", 32'(bus.door_close_lamp), 32'd1);
    @(negedge clk);
    chk("down_lamp_return", 32'(bus.down_lamp), 32'd1);
    chk("up_lamp_return", 32'(bus.up_lamp), 32'd0);
    wait_door(40);
    chk("served_1", 32'(bus.floor), 32'd1);

    // Call for the open-door floor restarts the timer and never latches
    run_ticks(2);
    chk("door_count_2", 32'(bus.count_door_time), 32'd2);
    pulse_out(8'b0000_0010);
    chk("here_not_latched", 32'(bus.floor_req), 32'd0);
    chk("here_restart", 32'(bus.count_door_time), 32'd0);
    run_ticks(4);
    chk("here_hold", 32'(bus.door_open_lamp), 32'd1);
    run_ticks(1);
    chk("here_closed", 32'(bus.door_close_lamp), 32'd1);
    chk("sb_drained", 32'(exp_floor_q.size()), 32'd0);

    // Reset mid-run between floors 5 and 6
    pulse_in(8'b1000_0000); exp_floor_q.push_back(7);
    run_ticks(12);
    chk("floor_5", 32'(bus.floor), 32'd5);
    run_ticks(1);
    chk("mid_run_count", 32'(bus.count_run_time), 32'd1);
    chk("mid_run_req", 32'(bus.floor_req), 32'h80);
    @(negedge clk); reset = 1'b0;
    exp_floor_q.delete();
    #1;
    chk("async_rst_floor", 32'(bus.floor), 32'd0);
    chk("async_rst_req", 32'(bus.floor_req), 32'd0);
    chk("async_rst_lamps", 32'({bus.up_lamp, bus.down_lamp, bus.door_open_lamp}), 32'd0);
    chk("async_rst_run", 32'(bus.count_run_time), 32'd0);
    @(negedge clk); reset = 1'b1;
    run_ticks(2);
    chk("post_rst_idle", 32'({bus.up_lamp, bus.down_lamp, bus.door_open_lamp}), 32'd0);
    chk("post_rst_floor", 32'(bus.floor), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
